// File: rtl/ring_pkg.sv
// Shared ring definitions for the memory-stop front end: slot encodings, Address-slot fields, token FSM states.
package ring_pkg;

    localparam logic [3:0] SLOT_TOKEN = 4'd1;
    localparam logic [3:0] SLOT_ADDR  = 4'd2;
    localparam logic [3:0] SLOT_WDATA = 4'd3;
    localparam logic [3:0] SLOT_NULL  = 4'd7;

    localparam int ADDR_READ_BIT = 28;

    typedef enum logic [1:0] {
        TOK_IDLE = 2'd0,
        TOK_SEND = 2'd1,
        TOK_WAIT = 2'd2
    } tok_state_t;

    // A dest entry is {local bit, id}; the id must hold a ring source id or a local reader index.
    function automatic int dest_id_w(input int src_w, input int n_local);
        return (src_w > $clog2(n_local)) ? src_w : $clog2(n_local);
    endfunction

endpackage

// File: rtl/ring_mem_destq.sv
// Destination queue: synchronous FIFO of pending read destinations.
// Latency: push visible at head one cycle later; pop is combinational from the head.
// Backpressure: full/empty flags; a pop frees space for a same-cycle push when full.
module ring_mem_destq #(
    parameter int DEPTH = 32,
    parameter int W     = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ring_mem_mux.sv
// Ring memory-stop front end: token source, Address/WriteData sink, read return, local reader arbitration.
// Latency: ring path, address issue, lack and read return combinational; ctl_wb_wr one cycle after last word.
// Backpressure: local grants stall on rif limit or full queue; ring reads never stall (overflow is sticky).
// Optional RING_MEM_METERS_EN adds per-slot-type occupancy counters read through mtr_sel/mtr_data.
module ring_mem_mux
    import ring_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 26,
    parameter int SRC_W      = 4,
    parameter int LINE_WORDS = 4,
    parameter int N_LOCAL    = 2,
    parameter int DQ_DEPTH   = 32,
    parameter int MAX_RIF    = 31
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            ring_in,
    input  logic [3:0]                   slot_type_in,
    input  logic [SRC_W-1:0]             source_in,
    output logic [DATA_W-1:0]            ring_out,
    output logic [3:0]                   slot_type_out,
    output logic [SRC_W-1:0]             source_out,
    output logic [DATA_W-1:0]            rd_return,
    output logic [SRC_W-1:0]             rd_dest,
    input  logic                         inhibit,
    input  logic [N_LOCAL-1:0]           lreq,
    input  logic [N_LOCAL*ADDR_W-1:0]    laddr,
    output logic [N_LOCAL-1:0]           lack,
    output logic [N_LOCAL-1:0]           lrd_valid,
    output logic [LINE_WORDS*DATA_W-1:0] lrd_data,
    output logic [ADDR_W-1:0]            ctl_addr,
    output logic                         ctl_af_wr,
    output logic                         ctl_read,
    output logic [LINE_WORDS*DATA_W-1:0] ctl_wd,
    output logic                         ctl_wb_wr,
    input  logic [LINE_WORDS*DATA_W-1:0] ctl_rd,
    input  logic                         ctl_rb_empty,
    output logic                         ctl_rb_rd,
`ifdef RING_MEM_METERS_EN
    input  logic [3:0]                   mtr_sel,
    output logic [DATA_W-1:0]            mtr_data,
`endif
    output logic                         err_overflow
);
    localparam int ID_W  = dest_id_w(SRC_W, N_LOCAL);
    localparam int WC_W  = $clog2(LINE_WORDS);
    localparam int PTR_W = (N_LOCAL > 1) ? $clog2(N_LOCAL) : 1;
    localparam int RIF_W = $clog2(MAX_RIF + 1);

    typedef struct packed {
        logic            is_local;
        logic [ID_W-1:0] id;
    } dest_t;

    tok_state_t                   state;
    logic [WC_W-1:0]              wcnt;
    logic [WC_W-1:0]              rcnt;
    logic [RIF_W-1:0]             rif;
    logic [PTR_W-1:0]             ptr;
    logic [LINE_WORDS*DATA_W-1:0] wd_line;

    logic                         is_addr, is_wdata, is_token, addr_read;
    logic                         grant_vld;
    logic [PTR_W-1:0]             grant_idx;
    logic [ADDR_W-1:0]            lsel_addr;
    logic                         push, pop, ring_rd_vld;
    dest_t                        push_d, head;
    logic [ID_W:0]                q_head;
    logic                         q_full, q_empty;

    assign is_addr   = (slot_type_in == SLOT_ADDR);
    assign is_wdata  = (slot_type_in == SLOT_WDATA);
    assign is_token  = (slot_type_in == SLOT_TOKEN);
    assign addr_read = ring_in[ADDR_READ_BIT];

    always_comb begin
        slot_type_out = slot_type_in;
        ring_out      = ring_in;
        source_out    = source_in;
        if (state == TOK_SEND) begin
            slot_type_out = SLOT_TOKEN;
            ring_out      = '0;
            source_out    = '0;
        end else if (is_token) begin
            slot_type_out = SLOT_NULL;
            ring_out      = '0;
            source_out    = '0;
        end
    end

    // Round robin: lowest requester at or above ptr wins, else lowest below ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = N_LOCAL - 1; i >= 0; i--) begin
            if (lreq[i] && PTR_W'(i) < ptr) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
        for (int i = N_LOCAL - 1; i >= 0; i--) begin
            if (lreq[i] && PTR_W'(i) >= ptr) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
        if (reset || is_addr || q_full || rif >= RIF_W'(MAX_RIF)) grant_vld = 1'b0;
    end

    always_comb begin
        lsel_addr = '0;
        lack      = '0;
        for (int i = 0; i < N_LOCAL; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                lsel_addr = laddr[i*ADDR_W +: ADDR_W];
                lack[i]   = grant_vld;
            end
        end
    end

    assign ctl_af_wr       = ~reset & (is_addr | grant_vld);
    assign ctl_addr        = is_addr ? ring_in[ADDR_W-1:0] : lsel_addr;
    assign ctl_read        = is_addr ? addr_read : grant_vld;
    assign ctl_wd          = wd_line;
    assign push            = ~reset & ((is_addr & addr_read) | grant_vld);
    assign push_d.is_local = ~is_addr;
    assign push_d.id       = is_addr ? ID_W'(source_in) : ID_W'(grant_idx);
    assign head            = q_head;
    assign lrd_data        = ctl_rd;

    always_comb begin
        rd_return   = '0;
        rd_dest     = '0;
        lrd_valid   = '0;
        ctl_rb_rd   = 1'b0;
        pop         = 1'b0;
        ring_rd_vld = 1'b0;
        if (!reset && !q_empty && !ctl_rb_empty) begin
            if (head.is_local) begin
                for (int i = 0; i < N_LOCAL; i++) lrd_valid[i] = (head.id == ID_W'(i));
                ctl_rb_rd = 1'b1;
                pop       = 1'b1;
            end else begin
                ring_rd_vld = 1'b1;
                rd_dest     = head.id[SRC_W-1:0];
                for (int k = 0; k < LINE_WORDS; k++)
                    if (rcnt == WC_W'(k)) rd_return = ctl_rd[k*DATA_W +: DATA_W];
                if (rcnt == WC_W'(LINE_WORDS - 1)) begin
                    ctl_rb_rd = 1'b1;
                    pop       = 1'b1;
                end
            end
        end
    end

    ring_mem_destq #(
        .DEPTH (DQ_DEPTH),
        .W     (ID_W + 1)
    ) u_destq (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (push_d),
        .pop      (pop),
        .pop_dat  (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= TOK_IDLE;
            wcnt         <= '0;
            rcnt         <= '0;
            rif          <= '0;
            ptr          <= '0;
            wd_line      <= '0;
            ctl_wb_wr    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                TOK_IDLE: if (!inhibit) state <= TOK_SEND;
                TOK_SEND: state <= TOK_WAIT;
                TOK_WAIT: if (is_token) state <= inhibit ? TOK_IDLE : TOK_SEND;
                default:  state <= TOK_IDLE;
            endcase

            ctl_wb_wr <= is_wdata && (wcnt == WC_W'(LINE_WORDS - 1));
            if (is_wdata) begin
                wcnt <= wcnt + WC_W'(1);
                for (int k = 0; k < LINE_WORDS; k++)
                    if (wcnt == WC_W'(k)) wd_line[k*DATA_W +: DATA_W] <= ring_in;
            end

            if (ring_rd_vld) rcnt <= rcnt + WC_W'(1);

            if (grant_vld)
                ptr <= (grant_idx == PTR_W'(N_LOCAL - 1)) ? '0 : grant_idx + PTR_W'(1);

            case ({grant_vld, pop & head.is_local})
                2'b10:   rif <= rif + RIF_W'(1);
                2'b01:   rif <= rif - RIF_W'(1);
                default: rif <= rif;
            endcase

            if (push && q_full && !pop) err_overflow <= 1'b1;
        end
    end

`ifdef RING_MEM_METERS_EN
    logic [DATA_W-1:0] mtr_cnt [16];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mtr_cnt[i] <= '0;
        end else if (state == TOK_WAIT) begin
            mtr_cnt[slot_type_in] <= mtr_cnt[slot_type_in] + DATA_W'(1);
        end
    end

    assign mtr_data = mtr_cnt[mtr_sel];
`endif

endmodule

// File: tb/tb_ring_mem_mux.sv
// Self-checking bench for ring_mem_mux: pass-through table, token FSM, write/read lines, arbitration, limits, reset.
module tb_ring_mem_mux;
    localparam int DATA_W = 32, ADDR_W = 26, SRC_W = 4, LINE_WORDS = 4;
    localparam int N_LOCAL = 2, DQ_DEPTH = 32, MAX_RIF = 31;
    localparam int LINE_W = LINE_WORDS * DATA_W;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [DATA_W-1:0]         ring_in = '0, ring_out;
    logic [3:0]                slot_type_in = 4'd7, slot_type_out;
    logic [SRC_W-1:0]          source_in = '0, source_out;
    logic [DATA_W-1:0]         rd_return;
    logic [SRC_W-1:0]          rd_dest;
    logic                      inhibit = 1'b1;
    logic [N_LOCAL-1:0]        lreq = '0, lack, lrd_valid;
    logic [N_LOCAL*ADDR_W-1:0] laddr = '0;
    logic [LINE_W-1:0]         lrd_data, ctl_wd, ctl_rd = '0;
    logic [ADDR_W-1:0]         ctl_addr;
    logic                      ctl_af_wr, ctl_read, ctl_wb_wr, ctl_rb_rd, err_overflow;
    logic                      ctl_rb_empty = 1'b1;
`ifdef RING_MEM_METERS_EN
    logic [3:0]                mtr_sel = '0;
    logic [DATA_W-1:0]         mtr_data;
`endif

    ring_mem_mux dut (
        .clock(clock), .reset(reset),
        .ring_in(ring_in), .slot_type_in(slot_type_in), .source_in(source_in),
        .ring_out(ring_out), .slot_type_out(slot_type_out), .source_out(source_out),
        .rd_return(rd_return), .rd_dest(rd_dest), .inhibit(inhibit),
        .lreq(lreq), .laddr(laddr), .lack(lack), .lrd_valid(lrd_valid), .lrd_data(lrd_data),
        .ctl_addr(ctl_addr), .ctl_af_wr(ctl_af_wr), .ctl_read(ctl_read),
        .ctl_wd(ctl_wd), .ctl_wb_wr(ctl_wb_wr), .ctl_rd(ctl_rd),
        .ctl_rb_empty(ctl_rb_empty), .ctl_rb_rd(ctl_rb_rd),
`ifdef RING_MEM_METERS_EN
        .mtr_sel(mtr_sel), .mtr_data(mtr_data),
`endif
        .err_overflow(err_overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_local;
        int          id;
        logic [31:0] word;
        logic        last;
    } exp_t;

    typedef struct {
        logic [3:0]  t;  logic [31:0] d;  logic [3:0] s;
        logic [3:0]  te; logic [31:0] de; logic [3:0] se;
        logic        af; logic        rd; logic [25:0] addr;
    } vec_t;

    exp_t              sb[$];
    logic [LINE_W-1:0] lines[$];
    vec_t              vecs[7];
    int                exp_lack[6];
    logic              blk[6];
    logic [LINE_W-1:0] line;
    int                checks = 0;
    int                errors = 0;
    int                grants;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_slot(input logic [3:0] t, input logic [31:0] d, input logic [SRC_W-1:0] s);
        slot_type_in = t;
        ring_in      = d;
        source_in    = s;
    endtask

    task automatic update_rb();
        ctl_rb_empty = (lines.size() == 0);
        ctl_rd       = (lines.size() != 0) ? lines[0] : '0;
    endtask

    task automatic next_cycle();
        @(negedge clock);
        set_slot(4'd7, 32'h0, '0);
        lreq = '0;
        update_rb();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        inhibit = 1'b1;
        set_slot(4'd7, 32'h0, '0);
        lreq = '0;
        sb.delete();
        lines.delete();
        update_rb();
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LINE_WORDS; k++) l[k*DATA_W +: DATA_W] = base + 32'(k);
        return l;
    endfunction

    task automatic push_ring_line(input int src, input logic [31:0] base);
        for (int k = 0; k < LINE_WORDS; k++)
            sb.push_back('{1'b0, src, base + 32'(k), (k == LINE_WORDS - 1)});
    endtask

    // Compares every read-return event against the scoreboard head, consuming controller lines on ctl_rb_rd.
    task automatic drain(input int budget);
        exp_t e;
        logic [N_LOCAL-1:0] oh;
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            next_cycle();
            #1;
            n++;
            if (rd_dest != 0 || lrd_valid != 0) begin
                e = sb.pop_front();
                if (e.is_local) begin
                    oh = '0;
                    oh[e.id] = 1'b1;
                    chk("lrd_valid", lrd_valid, oh);
                    chk("lrd_data", lrd_data, lines[0]);
                    chk("lrd_rb_rd", ctl_rb_rd, 1'b1);
                    chk("lrd_no_ring", rd_dest, 0);
                end else begin
                    chk("rd_dest", rd_dest, e.id);
                    chk("rd_return", rd_return, e.word);
                    chk("rd_rb_rd", ctl_rb_rd, e.last);
                end
                if (ctl_rb_rd && lines.size() != 0) void'(lines.pop_front());
            end
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd7, 32'h0,        4'd0,  4'd7, 32'h0,        4'd0,  1'b0, 1'b0, 26'h0};
        vecs[1] = '{4'd1, 32'h0,        4'd0,  4'd7, 32'h0,        4'd0,  1'b0, 1'b0, 26'h0};
        vecs[2] = '{4'd2, 32'h00000123, 4'd2,  4'd2, 32'h00000123, 4'd2,  1'b1, 1'b0, 26'h123};
        vecs[3] = '{4'd2, 32'h13ABCDEF, 4'd5,  4'd2, 32'h13ABCDEF, 4'd5,  1'b1, 1'b1, 26'h3ABCDEF};
        vecs[4] = '{4'd3, 32'hDEADBEEF, 4'd1,  4'd3, 32'hDEADBEEF, 4'd1,  1'b0, 1'b0, 26'h0};
        vecs[5] = '{4'd5, 32'h0000CAFE, 4'd7,  4'd5, 32'h0000CAFE, 4'd7,  1'b0, 1'b0, 26'h0};
        vecs[6] = '{4'd2, 32'hEC000456, 4'd15, 4'd2, 32'hEC000456, 4'd15, 1'b1, 1'b0, 26'h456};
        exp_lack = '{1, 2, 1, 2, 0, 1};
        blk      = '{0, 0, 0, 0, 1, 0};

        // Reset: pulses held low, arriving token stripped even in reset.
        #3;
        lreq = 2'b11;
        ctl_rb_empty = 1'b0;
        set_slot(4'd1, 32'h0, 4'd3);
        #1;
        chk("rst_slot_type", slot_type_out, 4'd7);
        chk("rst_lack", lack, 0);
        chk("rst_rd_dest", rd_dest, 0);
        chk("rst_rd_return", rd_return, 0);
        chk("rst_lrd_valid", lrd_valid, 0);
        chk("rst_rb_rd", ctl_rb_rd, 0);
        chk("rst_wb_wr", ctl_wb_wr, 0);
        chk("rst_err", err_overflow, 0);
        set_slot(4'd2, 32'h10000123, 4'd3);
        #1;
        chk("rst_af_wr", ctl_af_wr, 0);
        do_reset();

        // Pass-through table with the token FSM idle.
        foreach (vecs[i]) begin
            next_cycle();
            set_slot(vecs[i].t, vecs[i].d, vecs[i].s);
            #1;
            chk("pt_type", slot_type_out, vecs[i].te);
            chk("pt_data", ring_out, vecs[i].de);
            chk("pt_src", source_out, vecs[i].se);
            chk("pt_af_wr", ctl_af_wr, vecs[i].af);
            if (vecs[i].af) begin
                chk("pt_addr", ctl_addr, vecs[i].addr);
                chk("pt_read", ctl_read, vecs[i].rd);
            end
        end

        // Token generation and stop on inhibit.
        do_reset();
        inhibit = 1'b0;
        #1 chk("tok_idle", slot_type_out, 4'd7);
        next_cycle(); #1;
        chk("tok_send", slot_type_out, 4'd1);
        chk("tok_data", ring_out, 0);
        chk("tok_src", source_out, 0);
        next_cycle(); #1 chk("tok_wait", slot_type_out, 4'd7);
        next_cycle(); set_slot(4'd1, 32'h0, '0); #1 chk("tok_strip", slot_type_out, 4'd7);
        next_cycle(); #1 chk("tok_reissue", slot_type_out, 4'd1);
        next_cycle(); inhibit = 1'b1; set_slot(4'd1, 32'h0, '0); #1 chk("tok_strip2", slot_type_out, 4'd7);
        next_cycle(); #1 chk("tok_stop1", slot_type_out, 4'd7);
        next_cycle(); #1 chk("tok_stop2", slot_type_out, 4'd7);

        // Ring write line.
        do_reset();
        next_cycle(); set_slot(4'd2, 32'h123, 4'd1); #1;
        chk("wr_af_wr", ctl_af_wr, 1);
        chk("wr_addr", ctl_addr, 26'h123);
        chk("wr_read", ctl_read, 0);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); set_slot(4'd3, 32'hA + 32'(k), 4'd1); #1;
            chk("wr_wb_early", ctl_wb_wr, 0);
        end
        next_cycle(); #1;
        chk("wr_wb_pulse", ctl_wb_wr, 1);
        chk("wr_line", ctl_wd, {32'hD, 32'hC, 32'hB, 32'hA});
        next_cycle(); #1 chk("wr_wb_end", ctl_wb_wr, 0);

        // Two ring reads returned word by word.
        do_reset();
        next_cycle(); set_slot(4'd2, 32'h10000040, 4'd5); #1;
        chk("rd_af_read", ctl_read, 1);
        chk("rd_addr", ctl_addr, 26'h40);
        chk("rd_idle", rd_dest, 0);
        push_ring_line(5, 32'h50000000);
        next_cycle(); set_slot(4'd2, 32'h10000080, 4'd9); #1;
        push_ring_line(9, 32'h90000000);
        lines.push_back(mk_line(32'h50000000));
        lines.push_back(mk_line(32'h90000000));
        drain(20);
        next_cycle(); #1 chk("rd_done", rd_dest, 0);

        // Local round robin, blocked by an Address slot, then local returns.
        do_reset();
        laddr = {26'h2BBBBBB, 26'h1AAAAAA};
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            lreq = 2'b11;
            if (blk[c]) set_slot(4'd2, 32'h777, 4'd3);
            #1;
            chk("arb_lack", lack, exp_lack[c]);
            if (exp_lack[c] != 0) begin
                chk("arb_addr", ctl_addr, laddr[(exp_lack[c] - 1)*ADDR_W +: ADDR_W]);
                chk("arb_read", ctl_read, 1);
                chk("arb_af", ctl_af_wr, 1);
                sb.push_back('{1'b1, exp_lack[c] - 1, 32'h0, 1'b1});
            end else begin
                chk("arb_blk_addr", ctl_addr, 26'h777);
            end
        end
        for (int k = 0; k < 5; k++) lines.push_back(mk_line(32'h0A000000 + 32'(k << 8)));
        drain(20);

        // In-flight limit: MAX_RIF grants, then one return allows one more.
        do_reset();
        grants = 0;
        for (int c = 0; c < MAX_RIF + 9; c++) begin
            next_cycle(); lreq = 2'b01; #1;
            if (lack == 2'b01) grants++;
            if (c >= MAX_RIF) chk("rif_stop", lack, 0);
        end
        chk("rif_grants", grants, MAX_RIF);
        lines.push_back(mk_line(32'h77000000));
        next_cycle(); lreq = 2'b01; #1;
        chk("rif_ret_valid", lrd_valid, 2'b01);
        chk("rif_ret_lack", lack, 0);
        void'(lines.pop_front());
        next_cycle(); lreq = 2'b01; #1 chk("rif_regrant", lack, 2'b01);
        next_cycle(); lreq = 2'b01; #1 chk("rif_stop2", lack, 0);
        chk("rif_no_err", err_overflow, 0);

        // Queue full: push+pop succeeds, then a further push overflows stickily.
        do_reset();
        for (int r = 0; r < DQ_DEPTH; r++) begin
            next_cycle(); set_slot(4'd2, 32'h10000000 | 32'(r), 4'd3);
        end
        next_cycle(); lreq = 2'b01; #1;
        chk("full_no_err", err_overflow, 0);
        chk("full_blocks_local", lack, 0);
        lines.push_back(mk_line(32'h33000000));
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1 chk("full_rd_dest", rd_dest, 3);
        end
        next_cycle(); set_slot(4'd2, 32'h10000099, 4'd3); #1;
        chk("full_pop_last", ctl_rb_rd, 1);
        void'(lines.pop_front());
        next_cycle(); #1 chk("full_push_pop", err_overflow, 0);
        set_slot(4'd2, 32'h1000009A, 4'd3);
        next_cycle(); #1 chk("ovf_set", err_overflow, 1);
        for (int k = 0; k < 5; k++) begin
            next_cycle(); #1 chk("ovf_sticky", err_overflow, 1);
        end
        do_reset();
        #1 chk("ovf_clear", err_overflow, 0);

        // Asynchronous reset mid-burst, then a clean write line after a discarded partial one.
        next_cycle(); set_slot(4'd3, 32'h1, '0);
        next_cycle(); set_slot(4'd3, 32'h2, '0);
        next_cycle(); set_slot(4'd2, 32'h10000010, 4'd6);
        lines.push_back(mk_line(32'h60000000));
        next_cycle(); #1 chk("ar_w0", rd_dest, 6);
        next_cycle(); #1 chk("ar_w1", rd_dest, 6);
        next_cycle(); #1;
        chk("ar_w2_dest", rd_dest, 6);
        chk("ar_w2_word", rd_return, 32'h60000002);
        #2 reset = 1'b1;
        #1;
        chk("ar_rd_dest", rd_dest, 0);
        chk("ar_rd_return", rd_return, 0);
        chk("ar_rb_rd", ctl_rb_rd, 0);
        @(negedge clock);
        reset = 1'b0;
        lines.delete();
        for (int k = 0; k < 4; k++) begin
            next_cycle(); set_slot(4'd3, 32'h11 + 32'(k), '0); #1;
            chk("ar_wb_early", ctl_wb_wr, 0);
        end
        next_cycle(); #1;
        chk("ar_wb_pulse", ctl_wb_wr, 1);
        chk("ar_wd_line", ctl_wd, {32'h14, 32'h13, 32'h12, 32'h11});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
